// File: rtl/coax_tx_word_if.sv
// coax_tx_word_if: word handshake between host logic and the coax transmitter.
// master drives data/load, slave answers with ready.
`timescale 1ns/1ps
interface coax_tx_word_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] data;
  logic                  load;
  logic                  ready;

  modport master (
    output data,
    output load,
    input  ready
  );

  modport slave (
    input  data,
    input  load,
    output ready
  );
endinterface

// File: rtl/coax_tx_word.sv
// coax_tx_word: word-level 3270 coax Manchester transmitter (quiesce, CV, words, end).
// Optional COAX_TX_DELAY_EN adds tx_delay, tx lagged DELAY_CLOCKS cycles.
`timescale 1ns/1ps
module coax_tx_word #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int QUIESCE_BITS   = 6,
  parameter int DATA_WIDTH     = 10
`ifdef COAX_TX_DELAY_EN
  ,
  parameter int DELAY_CLOCKS   = 2
`endif
) (
  input  logic           clk,
  input  logic           reset,
  coax_tx_word_if.slave  bus,
  output logic           tx,
`ifdef COAX_TX_DELAY_EN
  output logic           tx_delay,
`endif
  output logic           active
);

  localparam int HALF = CLOCKS_PER_BIT / 2;
  localparam int BCW  = $clog2(CLOCKS_PER_BIT);
  localparam int MAXA = (QUIESCE_BITS > DATA_WIDTH) ?
                        QUIESCE_BITS : DATA_WIDTH;
  localparam int MAXB = (MAXA > 3) ? MAXA : 3;
  localparam int IW   = $clog2(MAXB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_CODE_VIOL,
    S_SYNC,
    S_DATA,
    S_PARITY,
    S_END
  } state_t;

  state_t                state, state_n;
  logic [BCW-1:0]        bit_counter;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_q;

  logic bit_strobe;
  logic first_half;
  logic fetch;
  logic idx_clr;
  logic accept;

  assign bit_strobe = (bit_counter == BCW'(CLOCKS_PER_BIT - 1));
  assign first_half = (bit_counter < BCW'(HALF));
  assign bus.ready  = ~hold_full;
  assign accept     = bus.load & ~hold_full;
  assign active     = (state != S_IDLE);

  // Next state, word fetch and the Manchester line level.
  always_comb begin
    state_n = state;
    fetch   = 1'b0;
    idx_clr = 1'b0;
    tx      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (hold_full) begin
          state_n = S_QUIESCE;
          idx_clr = 1'b1;
        end
      end
      S_QUIESCE: begin
        tx = ~first_half;
        if (bit_strobe &&
            bit_idx == IW'(QUIESCE_BITS - 1)) begin
          state_n = S_CODE_VIOL;
          idx_clr = 1'b1;
        end
      end
      S_CODE_VIOL: begin
        tx = (bit_idx == IW'(0)) |
             ((bit_idx == IW'(1)) & first_half);
        if (bit_strobe && bit_idx == IW'(2)) begin
          state_n = S_SYNC;
          fetch   = 1'b1;
          idx_clr = 1'b1;
        end
      end
      S_SYNC: begin
        tx = ~first_half;
        if (bit_strobe) begin
          state_n = S_DATA;
          idx_clr = 1'b1;
        end
      end
      S_DATA: begin
        tx = shift_q[DATA_WIDTH-1] ^ first_half;
        if (bit_strobe &&
            bit_idx == IW'(DATA_WIDTH - 1)) begin
          state_n = S_PARITY;
          idx_clr = 1'b1;
        end
      end
      S_PARITY: begin
        tx = par_q ^ first_half;
        if (bit_strobe) begin
          idx_clr = 1'b1;
          if (hold_full) begin
            state_n = S_SYNC;
            fetch   = 1'b1;
          end else begin
            state_n = S_END;
          end
        end
      end
      S_END: begin
        tx = first_half;
        if (bit_strobe) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, bit timing, holding register and shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      bit_counter <= '0;
      bit_idx     <= '0;
      hold_q      <= '0;
      hold_full   <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE || bit_strobe) begin
        bit_counter <= '0;
      end else begin
        bit_counter <= bit_counter + 1'b1;
      end
      if (idx_clr) begin
        bit_idx <= '0;
      end else if (bit_strobe) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (accept) begin
        hold_q <= bus.data;
      end
      hold_full <= accept | (hold_full & ~fetch);
      if (fetch) begin
        shift_q <= hold_q;
        par_q   <= ~^hold_q;
      end else if (state == S_DATA && bit_strobe) begin
        shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

`ifdef COAX_TX_DELAY_EN
  logic [DELAY_CLOCKS-1:0] dly_q;
  logic [DELAY_CLOCKS:0]   dly_in;

  assign dly_in   = {dly_q, tx};
  assign tx_delay = dly_q[DELAY_CLOCKS-1];

  // Pre-emphasis copy of the line, lagging by DELAY_CLOCKS.
  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_in[DELAY_CLOCKS-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_coax_tx_word.sv
// tb_coax_tx_word: scoreboard bench, frame-level reference model of the line.
// Directed scenarios plus randomized loads and resets.
`timescale 1ns/1ps
module tb_coax_tx_word;
  localparam int CPB  = 8;
  localparam int QB   = 6;
  localparam int DW   = 10;
  localparam int HALF = CPB / 2;
  localparam int K_IDLE = 0;
  localparam int K_PRE  = 1;
  localparam int K_WORD = 2;
  localparam int K_END  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic active;
`ifdef COAX_TX_DELAY_EN
  logic tx_delay;
`endif

  coax_tx_word_if #(.DATA_WIDTH(DW)) bus();

  coax_tx_word dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .tx       (tx),
`ifdef COAX_TX_DELAY_EN
    .tx_delay (tx_delay),
`endif
    .active   (active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic a;
    logic r;
    logic t;
    logic d;
  } obs_t;

  bit          seg[$];
  int          kind;
  bit          m_full;
  logic [DW-1:0] m_hold;
  bit          ptx;
  bit [1:0]    hist;
  obs_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  function automatic void push_bit(bit b);
    for (int i = 0; i < CPB; i++)
      seg.push_back((i < HALF) ? !b : b);
  endfunction

  function automatic void push_pre();
    for (int i = 0; i < QB; i++) push_bit(1'b1);
    for (int i = 0; i < 3 * CPB; i++)
      seg.push_back(i < (3 * CPB) / 2);
  endfunction

  function automatic void push_word(logic [DW-1:0] w);
    int ones;
    push_bit(1'b1);
    for (int k = DW - 1; k >= 0; k--) push_bit(w[k]);
    ones = 1 + $countones(w);
    push_bit((ones % 2) == 1);
  endfunction

  function automatic void model_step(bit rst, bit ld,
                                     logic [DW-1:0] d);
    bit fetch;
    bit accept;
    if (rst) begin
      seg.delete();
      kind = K_IDLE;
      m_full = 1'b0;
      return;
    end
    accept = ld && !m_full;
    fetch = 1'b0;
    if (seg.size() != 0) begin
      void'(seg.pop_front());
      if (seg.size() == 0) begin
        if (kind == K_PRE) fetch = 1'b1;
        else if (kind == K_WORD) begin
          if (m_full) fetch = 1'b1;
          else begin
            push_bit(1'b0);
            kind = K_END;
          end
        end else kind = K_IDLE;
      end
    end else if (m_full) begin
      push_pre();
      kind = K_PRE;
    end
    if (fetch) begin
      push_word(m_hold);
      kind = K_WORD;
      m_full = 1'b0;
    end
    if (accept) begin
      m_hold = d;
      m_full = 1'b1;
    end
  endfunction

  // Reference model advances on each edge and queues the next cycle's outputs.
  always @(posedge clk) begin
    obs_t o;
    cyc++;
    ptx = (seg.size() != 0) ? seg[0] : 1'b0;
    model_step(reset, bus.load, bus.data);
    if (reset) hist = 2'b00;
    else hist = {hist[0], ptx};
    o.a = (seg.size() != 0);
    o.r = !m_full;
    o.t = (seg.size() != 0) ? seg[0] : 1'b0;
    o.d = hist[1];
    sb.push_back(o);
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h want %0h",
               nm, cyc, act, req);
    end
  endtask

  // Monitor pops one expected sample per cycle and compares mid-cycle.
  initial begin
    obs_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("line{active,ready,tx}",
            {29'd0, active, bus.ready, tx},
            {29'd0, e.a, e.r, e.t});
`ifdef COAX_TX_DELAY_EN
        chk("tx_delay", {31'd0, tx_delay}, {31'd0, e.d});
`endif
      end
    end
  end

  task automatic drive(bit ld, logic [DW-1:0] d);
    @(posedge clk);
    #1;
    bus.load = ld;
    bus.data = d;
  endtask

  task automatic load_word(logic [DW-1:0] d);
    drive(1'b1, d);
    drive(1'b0, '0);
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  task automatic measure_active(int exp_len, string nm);
    int t;
    int len;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!active && t < 200);
    len = 0;
    while (active && len < 5000) begin
      len++;
      @(negedge clk);
    end
    chk(nm, len, exp_len);
  endtask

  initial begin
    bus.load = 1'b0;
    bus.data = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(3);

    fork
      measure_active(176, "len_one_word");
      load_word(10'h000);
    join
    idle_cycles(5);

    fork
      measure_active(272, "len_two_words");
      begin
        load_word(10'h001);
        idle_cycles(90);
        load_word(10'h3FF);
      end
    join
    idle_cycles(5);

    fork
      measure_active(176, "len_dropped_load");
      begin
        drive(1'b1, 10'h155);
        drive(1'b1, 10'h2AA);
        drive(1'b0, '0);
      end
    join
    idle_cycles(5);

    load_word(10'h0F0);
    idle_cycles(116);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    fork
      measure_active(176, "len_after_reset");
      load_word(10'h2C5);
    join
    idle_cycles(5);

    fork
      measure_active(176, "len_frame1");
      begin
        load_word(10'h1E1);
        idle_cycles(168);
        load_word(10'h3C3);
      end
    join
    measure_active(176, "len_frame2");
    idle_cycles(5);

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      bus.load = ($urandom_range(0, 39) == 0);
      bus.data = DW'($urandom);
      reset = ($urandom_range(0, 1999) == 0);
    end
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    reset = 1'b0;
    idle_cycles(400);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
